// File: rtl/pipe_pkg.sv
// Shared types and helpers for the back-pressure-aware pipeline stage.
package pipe_pkg;

  // Stage occupancy states; SKID means both the main and skid entries hold beats.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  // Default payload widths match the RV-NE EX/MEM stage.
  localparam int RVNE_EXMEM_DATA_W = 101;
  localparam int RVNE_EXMEM_CTRL_W = 9;

  // Saturating increment of a counter w bits wide (w <= 64). Callers
  // zero-extend into 64 bits and truncate the result back to their width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready beat interface: a data payload plus a separately handled control payload.
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = RVNE_EXMEM_DATA_W,
  parameter int CTRL_W = RVNE_EXMEM_CTRL_W
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// One stage entry: valid + control + data. Clearing control also drops valid,
// so ctrl is zero whenever the entry is empty. Clears win over load.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = RVNE_EXMEM_DATA_W,
  parameter int CTRL_W = RVNE_EXMEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_ctrl_i,
  input  logic              clear_data_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Next-state: clear beats load; data may be retained across a control clear.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_ctrl_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
    end
    if (clear_data_i)                 data_d = '0;
    else if (load_i && !clear_ctrl_i) data_d = data_i;
  end

  // Entry state flops, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Back-pressure-aware pipeline stage: main entry drives the outputs, a one-entry
// skid buffer absorbs the beat accepted while downstream stalls, so in_ready is
// a pure flop output. Synchronous flush plus saturating flush/stall counters.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W              = RVNE_EXMEM_DATA_W,
  parameter int CTRL_W              = RVNE_EXMEM_CTRL_W,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_skid_stage_if.slave  up_i,
  pipe_skid_stage_if.master dn_o,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  pipe_state_e state_q, state_d;

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data,  s_data,  m_data_in;
  logic [CTRL_W-1:0] m_ctrl,  s_ctrl,  m_ctrl_in;
  logic              m_load, m_clr_ctrl, m_clr_data, m_from_skid;
  logic              s_load, s_clr_ctrl, s_clr_data;
  logic              in_fire, out_fire;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d, stall_cnt_q, stall_cnt_d;

  // in_ready depends only on the skid valid flop.
  assign up_i.ready = ~s_valid;
  assign in_fire    = up_i.valid & ~s_valid;
  assign out_fire   = m_valid & dn_o.ready;

  // Entry controls and next state; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    m_load      = 1'b0;
    m_clr_ctrl  = 1'b0;
    m_clr_data  = 1'b0;
    m_from_skid = 1'b0;
    s_load      = 1'b0;
    s_clr_ctrl  = 1'b0;
    s_clr_data  = 1'b0;
    if (flush_i) begin
      m_clr_ctrl = 1'b1;
      s_clr_ctrl = 1'b1;
      m_clr_data = CLEAR_DATA_ON_FLUSH;
      s_clr_data = CLEAR_DATA_ON_FLUSH;
      state_d    = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          m_load  = 1'b1;
          state_d = FULL;
        end
        FULL: begin
          if (in_fire && out_fire) begin
            m_load = 1'b1;
          end else if (in_fire) begin
            s_load  = 1'b1;
            state_d = SKID;
          end else if (out_fire) begin
            m_clr_ctrl = 1'b1;
            state_d    = EMPTY;
          end
        end
        SKID: if (out_fire) begin
          // Skid beat is younger than main, so it moves up in order.
          m_load      = 1'b1;
          m_from_skid = 1'b1;
          s_clr_ctrl  = 1'b1;
          state_d     = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign m_data_in = m_from_skid ? s_data : up_i.data;
  assign m_ctrl_in = m_from_skid ? s_ctrl : up_i.ctrl;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk          (clk),
    .reset        (reset),
    .load_i       (m_load),
    .clear_ctrl_i (m_clr_ctrl),
    .clear_data_i (m_clr_data),
    .data_i       (m_data_in),
    .ctrl_i       (m_ctrl_in),
    .valid_o      (m_valid),
    .data_o       (m_data),
    .ctrl_o       (m_ctrl)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk          (clk),
    .reset        (reset),
    .load_i       (s_load),
    .clear_ctrl_i (s_clr_ctrl),
    .clear_data_i (s_clr_data),
    .data_i       (up_i.data),
    .ctrl_i       (up_i.ctrl),
    .valid_o      (s_valid),
    .data_o       (s_data),
    .ctrl_o       (s_ctrl)
  );

  assign dn_o.valid  = m_valid;
  assign dn_o.data   = m_data;
  assign dn_o.ctrl   = m_ctrl;
  assign occupancy_o = 2'(m_valid) + 2'(s_valid);

  // Counter next values: flushes that discard something, and stalled output cycles.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i && (m_valid || s_valid))
      flush_cnt_d = CNT_W'(sat_inc(64'(flush_cnt_q), CNT_W));
    if (m_valid && !dn_o.ready)
      stall_cnt_d = CNT_W'(sat_inc(64'(stall_cnt_q), CNT_W));
  end

  // FSM state and statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_cnt_o = flush_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  // A skid beat without a main beat would break ordering.
  a_skid_implies_main: assert property (@(posedge clk) disable iff (reset) s_valid |-> m_valid);
  // FSM state must agree with the entry valid bits.
  a_state_matches: assert property (@(posedge clk) disable iff (reset)
    (state_q == pipe_state_e'(occupancy_o)));

endmodule
